// File: rtl/rv32e_decode_stage_pkg.sv
// Shared decode constants: RV32 opcodes, execute operation classes, immediate formats.
package rv32e_decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] OPC_LUI    = 4'd0;
  localparam logic [3:0] OPC_AUIPC  = 4'd1;
  localparam logic [3:0] OPC_JAL    = 4'd2;
  localparam logic [3:0] OPC_JALR   = 4'd3;
  localparam logic [3:0] OPC_BRANCH = 4'd4;
  localparam logic [3:0] OPC_LOAD   = 4'd5;
  localparam logic [3:0] OPC_STORE  = 4'd6;
  localparam logic [3:0] OPC_OPIMM  = 4'd7;
  localparam logic [3:0] OPC_OP     = 4'd8;
  localparam logic [3:0] OPC_SYSTEM = 4'd9;
  localparam logic [3:0] OPC_NONE   = 4'd15;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_LUI, OP_AUIPC:                       fmt = IMM_U;
      OP_JAL:                                 fmt = IMM_J;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM:  fmt = IMM_I;
      OP_BRANCH:                              fmt = IMM_B;
      OP_STORE:                               fmt = IMM_S;
      default:                                fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/rv32e_imm_gen.sv
// Combinational RV32I immediate extraction; every format sign-extends from instr[31].
import rv32e_decode_stage_pkg::*;

module rv32e_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:7] instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt(opcode))
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[XLEN-1:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32e_decode_stage.sv
// RV32E decode stage: drives the register file read port on accept, registers control
// fields for execute, and stalls fetch on read-after-write hazards via a pending-write scoreboard.
import rv32e_decode_stage_pkg::*;

module rv32e_decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              rf_re,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_opclass,
  output logic [2:0]        ex_funct3,
  output logic              ex_alt,
  output logic              ex_writes_rd,
  output logic              ex_illegal,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush
);

  localparam int NREG = 1 << REG_AW;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [3:0]        opclass;
  logic              known, uses_rs1, uses_rs2, uses_rd;
  logic              funct7_bad, illegal, writes_rd;
  logic              hazard, accept;
  logic [XLEN-1:0]   imm;
  logic [NREG-1:0]   pending, pending_nxt;

  assign opcode  = if_instr[6:0];
  assign rs1_idx = if_instr[15 +: REG_AW];
  assign rs2_idx = if_instr[20 +: REG_AW];
  assign rd_idx  = if_instr[7 +: REG_AW];
  assign rf_rs1  = rs1_idx;
  assign rf_rs2  = rs2_idx;

  always_comb begin
    opclass  = OPC_NONE;
    known    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b0;
    case (opcode)
      OP_LUI:    begin opclass = OPC_LUI;    uses_rd = 1'b1; end
      OP_AUIPC:  begin opclass = OPC_AUIPC;  uses_rd = 1'b1; end
      OP_JAL:    begin opclass = OPC_JAL;    uses_rd = 1'b1; end
      OP_JALR:   begin opclass = OPC_JALR;   uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OP_BRANCH: begin opclass = OPC_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LOAD:   begin opclass = OPC_LOAD;   uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OP_STORE:  begin opclass = OPC_STORE;  uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_OPIMM:  begin opclass = OPC_OPIMM;  uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OP_OP:     begin opclass = OPC_OP;     uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_SYSTEM: begin opclass = OPC_SYSTEM; end
      default:   begin known = 1'b0; end
    endcase
  end

  // Register fields with bit 4 set name x16..x31, which RV32E does not have.
  assign funct7_bad = (opcode == OP_OP) && (if_instr[31:25] != 7'h00) && (if_instr[31:25] != 7'h20);
  assign illegal    = (if_instr[1:0] != 2'b11) || !known || funct7_bad
                    || (uses_rs1 && if_instr[19]) || (uses_rs2 && if_instr[24])
                    || (uses_rd && if_instr[11]);
  assign writes_rd  = uses_rd && (rd_idx != '0) && !illegal;

  rv32e_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .opcode (opcode),
    .instr  (if_instr[XLEN-1:7]),
    .imm    (imm)
  );

  // No writeback bypass: the register file reads the old value on its write edge.
  assign hazard   = (uses_rs1 && (rs1_idx != '0) && pending[rs1_idx])
                 || (uses_rs2 && (rs2_idx != '0) && pending[rs2_idx]);
  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  assign rf_re    = accept;

  always_comb begin
    pending_nxt = pending;
    if (wb_valid && (wb_rd != '0))
      pending_nxt[wb_rd] = 1'b0;
    if (flush && ex_valid && ex_writes_rd)
      pending_nxt[ex_rd] = 1'b0;
    // Applied last so a new claim beats a same-cycle retire of the same register.
    if (accept && writes_rd)
      pending_nxt[rd_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opclass   <= '0;
      ex_funct3    <= '0;
      ex_alt       <= 1'b0;
      ex_writes_rd <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      if (flush)
        ex_valid <= 1'b0;
      else if (accept)
        ex_valid <= 1'b1;
      else if (ex_ready)
        ex_valid <= 1'b0;

      if (accept) begin
        ex_pc        <= if_pc;
        ex_imm       <= imm;
        ex_rd        <= rd_idx;
        ex_opclass   <= opclass;
        ex_funct3    <= if_instr[14:12];
        ex_alt       <= if_instr[30];
        ex_writes_rd <= writes_rd;
        ex_illegal   <= illegal;
      end
    end
  end

endmodule
